// File: rtl/display_page_ctrl.sv
// display_page_ctrl: holds the displayed value and steps the page select on debounced key presses or auto-scroll ticks
module display_page_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iKey,
  input  logic        iAuto,
  input  logic        iFreeze,
  input  logic [63:0] iData,
  input  logic        iDataValid,
  output logic [63:0] oOutput,
  output logic [1:0]  oSelect,
  output logic        oPageStrobe
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = AUTO_PERIOD > 1 ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AMAX = AW'(AUTO_PERIOD - 1);

  logic          s1_q, s1_d, s2_q, s2_d, stable_q, stable_d, strobe_q, strobe_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [63:0]   out_q, out_d;
  logic          dmax, amax, press, tick, adv;

  always_comb begin
    s1_d     = iKey;
    s2_d     = s1_q;
    dmax     = dcnt_q == DMAX;
    amax     = acnt_q == AMAX;
    press    = stable_q & ~s2_q & dmax;
    tick     = iAuto & amax;
    adv      = press | tick;
    stable_d = (s2_q != stable_q && dmax) ? s2_q : stable_q;
    dcnt_d   = (s2_q == stable_q || dmax) ? '0 : dcnt_q + 1'b1;
    // a press restarts the auto period so the new page gets a full dwell
    acnt_d   = (!iAuto || press || amax) ? '0 : acnt_q + 1'b1;
    sel_d    = sel_q + {1'b0, adv};
    strobe_d = adv;
    out_d    = (iDataValid && !iFreeze) ? iData : out_q;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      stable_q <= 1'b1;
      dcnt_q   <= '0;
      acnt_q   <= '0;
      sel_q    <= '0;
      strobe_q <= 1'b0;
      out_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      acnt_q   <= acnt_d;
      sel_q    <= sel_d;
      strobe_q <= strobe_d;
      out_q    <= out_d;
    end
  end

  assign oOutput     = out_q;
  assign oSelect     = sel_q;
  assign oPageStrobe = strobe_q;
endmodule

// File: tb/tb_display_page_ctrl.sv
// tb_display_page_ctrl: directed plan items plus randomized stimulus against a history-based reference model
module tb_display_page_ctrl;
  localparam int DEB = 4;
  localparam int AP  = 8;

  logic        clk = 0;
  logic        rst_n, key, auto_en, freeze, valid;
  logic [63:0] data;
  logic [63:0] o_out;
  logic [1:0]  o_sel;
  logic        o_stb;
  int          n_chk = 0, n_err = 0;

  logic        m_s1, m_s2, m_stable, m_stb;
  logic [1:0]  m_sel;
  logic [63:0] m_out;
  int          m_ac;
  logic        hist[$];

  display_page_ctrl #(.DEBOUNCE_CYCLES(DEB), .AUTO_PERIOD(AP)) dut (
    .iCLK(clk), .iRST_n(rst_n), .iKey(key), .iAuto(auto_en), .iFreeze(freeze),
    .iData(data), .iDataValid(valid), .oOutput(o_out), .oSelect(o_sel), .oPageStrobe(o_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock edge: advance the model from the pre-edge inputs, then compare all outputs
  task automatic cyc();
    logic acc, press, tick;
    @(posedge clk);
    if (!rst_n) begin
      m_s1 = 1; m_s2 = 1; m_stable = 1; hist.delete();
      m_ac = 0; m_sel = 0; m_stb = 0; m_out = '0;
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      acc = hist.size() == DEB;
      foreach (hist[i]) if (hist[i] == m_stable) acc = 0;
      press = acc && m_stable;
      tick  = auto_en && m_ac == AP - 1;
      if (acc) m_stable = ~m_stable;
      m_ac  = (!auto_en || press || tick) ? 0 : m_ac + 1;
      if (press || tick) m_sel = m_sel + 2'd1;
      m_stb = press || tick;
      if (valid && !freeze) m_out = data;
      m_s2 = m_s1;
      m_s1 = key;
    end
    #1;
    chk("model_sel", {62'd0, o_sel}, {62'd0, m_sel});
    chk("model_stb", {63'd0, o_stb}, {63'd0, m_stb});
    chk("model_out", o_out, m_out);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press_key();
    key = 0;
    run(DEB + 4);
    key = 1;
    run(DEB + 4);
  endtask

  task automatic do_reset();
    rst_n = 0;
    cyc();
    rst_n = 1;
  endtask

  initial begin
    logic [1:0] exp_seq [4];
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 0;
    rst_n = 0; key = 1; auto_en = 0; freeze = 0; valid = 1; data = '1;
    m_s1 = 1; m_s2 = 1; m_stable = 1; m_ac = 0; m_sel = 0; m_stb = 0; m_out = '0;
    // reset holds outputs at zero even with valid data present
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_out", o_out, 64'd0);
      chk("rst_sel", {62'd0, o_sel}, 64'd0);
      chk("rst_stb", {63'd0, o_stb}, 64'd0);
    end
    rst_n = 1;
    cyc();
    chk("post_rst_out", o_out, 64'hFFFF_FFFF_FFFF_FFFF);
    valid = 0;
    run(3);
    // press latency: key low sampled from E1, page moves at E6
    key = 0;
    run(DEB + 1);
    chk("deb_e5_sel", {62'd0, o_sel}, 64'd0);
    cyc();
    chk("deb_e6_sel", {62'd0, o_sel}, 64'd1);
    chk("deb_e6_stb", {63'd0, o_stb}, 64'd1);
    cyc();
    chk("deb_e7_stb", {63'd0, o_stb}, 64'd0);
    run(100);
    chk("hold_sel", {62'd0, o_sel}, 64'd1);
    key = 1;
    run(10);
    chk("release_sel", {62'd0, o_sel}, 64'd1);
    press_key();
    chk("second_press", {62'd0, o_sel}, 64'd2);
    // bounce rejection then wrap through four presses
    do_reset();
    run(3);
    foreach (exp_seq[i]) begin
      logic [6:0] pat;
      pat = 7'b0001001;
      if (i == 0) begin
        for (int b = 6; b >= 0; b--) begin
          key = pat[b];
          cyc();
        end
        key = 1;
        run(10);
        chk("bounce_sel", {62'd0, o_sel}, 64'd0);
      end
      press_key();
      chk("wrap_sel", {62'd0, o_sel}, {62'd0, exp_seq[i]});
    end
    // auto-scroll with drop and re-raise, then coincident press and tick
    rst_n = 0;
    cyc();
    rst_n = 1;
    auto_en = 1;
    run(7);
    chk("auto_e7", {62'd0, o_sel}, 64'd0);
    cyc();
    chk("auto_e8", {62'd0, o_sel}, 64'd1);
    run(8);
    chk("auto_e16", {62'd0, o_sel}, 64'd2);
    run(4);
    auto_en = 0;
    run(10);
    auto_en = 1;
    run(7);
    chk("auto_e37", {62'd0, o_sel}, 64'd2);
    cyc();
    chk("auto_e38", {62'd0, o_sel}, 64'd3);
    run(2);
    key = 0;
    run(5);
    chk("coinc_e45", {62'd0, o_sel}, 64'd3);
    cyc();
    chk("coinc_e46", {62'd0, o_sel}, 64'd0);
    cyc();
    chk("coinc_e47", {62'd0, o_sel}, 64'd0);
    key = 1;
    auto_en = 0;
    run(10);
    // freeze and capture
    data = 64'h0123_4567_89AB_CDEF; valid = 1;
    cyc();
    chk("cap1", o_out, 64'h0123_4567_89AB_CDEF);
    freeze = 1; data = 64'hDEAD_BEEF_0000_0001;
    run(2);
    chk("frozen", o_out, 64'h0123_4567_89AB_CDEF);
    freeze = 0;
    cyc();
    chk("unfrozen", o_out, 64'hDEAD_BEEF_0000_0001);
    valid = 0; data = 64'h5555_AAAA_5555_AAAA;
    run(2);
    chk("hold_invalid", o_out, 64'hDEAD_BEEF_0000_0001);
    // reset mid-debounce discards progress
    do_reset();
    run(2);
    key = 0;
    run(3);
    rst_n = 0;
    cyc();
    rst_n = 1;
    run(DEB + 1);
    chk("mid_rst_e5", {62'd0, o_sel}, 64'd0);
    cyc();
    chk("mid_rst_e6", {62'd0, o_sel}, 64'd1);
    key = 1;
    run(10);
    // randomized traffic checked against the model every edge
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) key = ~key;
      if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
      freeze = $urandom_range(0, 3) == 0;
      valid  = $urandom_range(0, 1) == 1;
      data   = {$urandom, $urandom};
      rst_n  = $urandom_range(0, 299) != 0;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
